ex_mem_pipe: RTL
================

Name: ex_mem_pipe

Overview:
- Parametrised, registered execute/memory stage: operand forwarding, ALU, multi-cycle data memory and an EX/MEM output register, all in one block.
- Adds valid/ready handshakes on both sides, configurable memory latency, and two-level forwarding (own output register, then WB).
- Sits between the ID/EX register and the WB stage of the pipelined core.

Parameters:
DATA_W, 32, datapath width (operands, PC, ALU result, memory word)
REG_AW, 4, register-index width (RA, RB, WC)
DM_AW, 10, data-memory word-address width; depth = 2**DM_AW
DM_LAT, 2, data-memory access cycles (1..8)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
in_valid  in  1  ID/EX holds an instruction
in_ready  out  1  stage accepts this cycle
in_RA, in_RB, in_ex_WC  in  REG_AW  source and destination register indices
in_PC, in_PRA, in_PRB, in_se_out  in  DATA_W  PC, register operands, sign-extended immediate
in_S_MXSE  in  1  1: ALU B = in_se_out; 0: forwarded PRB
in_OP_ALU  in  5  ALU opcode (core encoding)
in_W_DM  in  1  store
in_S_MXRB  in  2  writeback select: 00 ALU, 01 memory (load), 10 PC
in_ex_W_RB  in  1  instruction writes register file
in_wb_WC  in  REG_AW  WB destination
in_wb_W_RB  in  1  WB write enable
in_mxrb  in  DATA_W  WB writeback value
out_valid  out  1  output register holds a result
out_ready  in  1  WB accepts
out_WC  out  REG_AW; out_PC, out_alu_res, out_PR  out  DATA_W; out_flags  out  4  {Z,C,S,O}, bit0 = O; out_S_MXRB  out  2; out_W_RB  out  1

Behaviour:
- Reset: every out_* register = 0, out_valid = 0, FSM = IDLE, latency counter = 0. Memory contents are not affected.
- Operand A forwarding priority:
  - own output register, when out_valid & out_W_RB & out_WC == in_RA; value selected by out_S_MXRB: 00 out_alu_res, 01 out_PR, 10 out_PC;
  - else WB, when in_wb_W_RB & in_wb_WC == in_RA: in_mxrb;
  - else in_PRA.
- Operand B: same priority, compared against in_RB. in_S_MXSE then picks immediate vs forwarded B.
- Register index 0 is ordinary; no hardwired zero.
- Memory address = alu_res[DM_AW-1:0], word-addressed. Store data = forwarded B (before the SE mux).
- Accept condition: in_ready = (state == IDLE) & (!out_valid | out_ready).
- Non-memory op accepted: output register loads on the next edge; 1-cycle latency.
- Memory op (load or store) accepted:
  - DM_LAT == 1: completes in the accept cycle, same as a non-memory op.
  - DM_LAT > 1: operands, ALU result and control are latched; FSM goes to MEM; counter counts DM_LAT-1 cycles.
  - On the final MEM cycle: store writes the array, load reads it, output register loads, FSM returns to IDLE.
  - Latency = DM_LAT cycles; in_ready = 0 throughout MEM.
- Loads: out_PR = read word. Non-loads: out_PR = 0.
- Forwarding during MEM uses the latched operands; no re-forwarding.
- out_valid & !out_ready: output register holds; no new accept.
- Output register drained with no new accept: out_valid falls.
- Output and input in the same cycle: simultaneous drain and accept allowed, giving full throughput for non-memory ops.
- RESET during MEM: access aborted, pending store not written, FSM = IDLE.
- Flags come from the ALU on every op, including memory ops.

Optional Feature:
- Macro: EXMEM_SELF_FWD_EN.
- Defined: own-output-register forwarding enabled, as above.
- Undefined: forwarding is from WB only; the hazard unit must stall dependent instructions one extra cycle; compare logic is removed.

Decomposition:
- Package exm_pkg:
  - S_MXRB codes (MXRB_ALU = 2'b00, MXRB_MEM = 2'b01, MXRB_PC = 2'b10);
  - FSM enum {IDLE, MEM};
  - flag bit indices (FLAG_O = 0, FLAG_S = 1, FLAG_C = 2, FLAG_Z = 3).
- One sub-module, exm_fwd_mux (DATA_W, REG_AW): a single-operand priority forwarder, instantiated twice. The existing alu is reused with width DATA_W.

Test Plan:
- ADD: in_PRA = 5, in_PRB = 7, no hazards -> out_alu_res = 12, out_flags = 0, out_valid one cycle after accept.
- Back-to-back dependency: instr1 WC = 3 result 12, instr2 RA = 3 with in_PRA = 0 -> instr2 uses 12 (self-forward). Same case with the macro undefined -> uses 0.
- WB and self both match RA: in_mxrb = 99, self = 12 -> 12 chosen. Only WB matches -> 99.
- DM_LAT = 3: store 0xDEAD to address 4, then load address 4 -> in_ready low 2 cycles per op, out_PR = 0xDEAD three cycles after load accept.
- out_ready held low 4 cycles with in_valid high -> outputs stable, in_ready = 0, no instruction lost.
- RESET asserted mid-MEM during a store to address 8 -> outputs zero, subsequent load of address 8 returns its prior value.

Source files
------------

// File: rtl/exm_pkg.sv
// exm_pkg: writeback-select codes, FSM states, flag indices and ALU opcodes for ex_mem_pipe.
package exm_pkg;
    localparam logic [1:0] MXRB_ALU = 2'b00;
    localparam logic [1:0] MXRB_MEM = 2'b01;
    localparam logic [1:0] MXRB_PC  = 2'b10;
    typedef enum logic {IDLE, MEM} state_t;
    localparam int FLAG_O = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 3;
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_PASSB = 5'd8;
endpackage

// File: rtl/alu.sv
// alu: core ALU; flags {Z,C,S,O}, C is carry-out on ADD and borrow on SUB.
module alu
    import exm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        op,
    output logic [DATA_W-1:0] res,
    output logic [3:0]        flags
);
    localparam int SW = $clog2(DATA_W);
    localparam int M = DATA_W - 1;
    logic [DATA_W:0] sum, dif;
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    always_comb begin
        res = op == ALU_ADD   ? sum[M:0] :
              op == ALU_SUB   ? dif[M:0] :
              op == ALU_AND   ? a & b :
              op == ALU_OR    ? a | b :
              op == ALU_XOR   ? a ^ b :
              op == ALU_SLL   ? a << b[SW-1:0] :
              op == ALU_SRL   ? a >> b[SW-1:0] :
              op == ALU_SRA   ? DATA_W'($signed(a) >>> b[SW-1:0]) :
              op == ALU_PASSB ? b : '0;
        flags = '0;
        flags[FLAG_Z] = res == '0;
        flags[FLAG_S] = res[M];
        flags[FLAG_C] = op == ALU_ADD ? sum[DATA_W] : op == ALU_SUB ? dif[DATA_W] : 1'b0;
        flags[FLAG_O] = op == ALU_ADD ? (a[M] == b[M]) && (res[M] != a[M]) :
                        op == ALU_SUB ? (a[M] != b[M]) && (res[M] != a[M]) : 1'b0;
    end
endmodule

// File: rtl/exm_fwd_mux.sv
// exm_fwd_mux: single-operand forwarder; own output register beats WB, which beats the register file.
// Own-register forwarding exists only when EXMEM_SELF_FWD_EN is defined.
module exm_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              self_en,
    input  logic [REG_AW-1:0] self_wc,
    input  logic [DATA_W-1:0] self_val,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_wc,
    input  logic [DATA_W-1:0] wb_val,
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] reg_val,
    output logic [DATA_W-1:0] fwd
);
`ifdef EXMEM_SELF_FWD_EN
    assign fwd = (self_en && self_wc == idx) ? self_val :
                 (wb_en && wb_wc == idx) ? wb_val : reg_val;
`else
    logic unused_self;
    assign unused_self = ^{self_en, self_wc, self_val};
    assign fwd = (wb_en && wb_wc == idx) ? wb_val : reg_val;
`endif
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: registered EX/MEM stage with forwarding, ALU, multi-cycle data memory and handshakes.
// Define EXMEM_SELF_FWD_EN to forward from the stage's own output register as well as from WB.
module ex_mem_pipe
    import exm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int DM_AW  = 10,
    parameter int DM_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_RA,
    input  logic [REG_AW-1:0] in_RB,
    input  logic [REG_AW-1:0] in_ex_WC,
    input  logic [DATA_W-1:0] in_PC,
    input  logic [DATA_W-1:0] in_PRA,
    input  logic [DATA_W-1:0] in_PRB,
    input  logic [DATA_W-1:0] in_se_out,
    input  logic              in_S_MXSE,
    input  logic [4:0]        in_OP_ALU,
    input  logic              in_W_DM,
    input  logic [1:0]        in_S_MXRB,
    input  logic              in_ex_W_RB,
    input  logic [REG_AW-1:0] in_wb_WC,
    input  logic              in_wb_W_RB,
    input  logic [DATA_W-1:0] in_mxrb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_WC,
    output logic [DATA_W-1:0] out_PC,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_PR,
    output logic [3:0]        out_flags,
    output logic [1:0]        out_S_MXRB,
    output logic              out_W_RB
);
    localparam bit MULTI = DM_LAT > 1;
    // pr carries store data while pending and the loaded word once completed
    typedef struct packed {
        logic [REG_AW-1:0] wc;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] pr;
        logic [3:0]        flags;
        logic [1:0]        mxrb;
        logic              wrb;
    } rec_t;
    rec_t out_q, out_d, pend_q, pend_d, cur, src, fin;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic out_valid_q, out_valid_d, pend_wdm_q, pend_wdm_d;
    logic acc, is_mem, start, done_mem, load, mem_we;
    logic [DATA_W-1:0] self_val, fwd_a, fwd_b, alu_b, alu_res, rd;
    logic [3:0] alu_flags;
    logic [DM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem [2**DM_AW];

    assign self_val = out_q.mxrb == MXRB_PC ? out_q.pc : out_q.mxrb == MXRB_MEM ? out_q.pr : out_q.res;

    exm_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .self_en(out_valid_q && out_q.wrb), .self_wc(out_q.wc), .self_val(self_val),
        .wb_en(in_wb_W_RB), .wb_wc(in_wb_WC), .wb_val(in_mxrb),
        .idx(in_RA), .reg_val(in_PRA), .fwd(fwd_a)
    );
    exm_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .self_en(out_valid_q && out_q.wrb), .self_wc(out_q.wc), .self_val(self_val),
        .wb_en(in_wb_W_RB), .wb_wc(in_wb_WC), .wb_val(in_mxrb),
        .idx(in_RB), .reg_val(in_PRB), .fwd(fwd_b)
    );

    assign alu_b = in_S_MXSE ? in_se_out : fwd_b;
    alu #(.DATA_W(DATA_W)) u_alu (.a(fwd_a), .b(alu_b), .op(in_OP_ALU), .res(alu_res), .flags(alu_flags));

    assign in_ready = state_q == IDLE && (!out_valid_q || out_ready);
    assign acc = in_valid && in_ready;
    assign is_mem = in_W_DM || in_S_MXRB == MXRB_MEM;
    assign start = acc && is_mem && MULTI;
    assign done_mem = state_q == MEM && cnt_q == '0;
    assign load = done_mem || (acc && !start);
    assign cur = '{in_ex_WC, in_PC, alu_res, fwd_b, alu_flags, in_S_MXRB, in_ex_W_RB};
    assign src = done_mem ? pend_q : cur;
    assign mem_addr = src.res[DM_AW-1:0];
    // a reset in the final MEM cycle must suppress the pending store
    assign mem_we = !RESET && load && (done_mem ? pend_wdm_q : in_W_DM);
    assign rd = mem[mem_addr];

    always_comb begin
        fin = src;
        fin.pr = src.mxrb == MXRB_MEM ? rd : '0;
        out_d = load ? fin : out_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        pend_d = start ? cur : pend_q;
        pend_wdm_d = start ? in_W_DM : pend_wdm_q;
        state_d = done_mem ? IDLE : start ? MEM : state_q;
        cnt_d = start ? 4'(DM_LAT - 2) : (state_q == MEM && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q <= '0;
            out_q <= '0;
            out_valid_q <= 1'b0;
            pend_q <= '0;
            pend_wdm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            out_valid_q <= out_valid_d;
            pend_q <= pend_d;
            pend_wdm_q <= pend_wdm_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= src.pr;
    end

    assign out_valid = out_valid_q;
    assign out_WC = out_q.wc;
    assign out_PC = out_q.pc;
    assign out_alu_res = out_q.res;
    assign out_PR = out_q.pr;
    assign out_flags = out_q.flags;
    assign out_S_MXRB = out_q.mxrb;
    assign out_W_RB = out_q.wrb;
endmodule
